uart_rx_fifo: RTL and testbench

Receive-side buffer placed directly downstream of the UART receiver, in the same `clock_x8` domain. It detects the receiver's `need_store` rising edge, captures the received data word together with its parity-error flag into a circular FIFO, and presents entries to the core through a valid/ready handshake. It also tracks overflow and, optionally, counts line errors.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_fifo_mem.sv | 36 +++
 rtl/uart_rx_fifo.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: receiver state encodings, the
//                default maximum word width, and the layout of a stored
//                receive-FIFO entry.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Widest data word the receiver can be configured for
    localparam int UART_WIDTH_MAX = 16;

    // Receiver state encodings
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_STORE  = 3'd5
    } uart_rx_state_e;

    // A FIFO entry is {parity_error, data}; the flag sits just above the data
    function automatic int entry_parity_bit(input int width);
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_mem
//  Description : DEPTH x (WIDTH+1) register array, one synchronous write port
//                and one asynchronous read port. Contents are not reset;
//                validity is tracked by the pointers in the parent.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = UART_WIDTH_MAX,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH:0]   i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH:0]   o_rdata
);

    logic [WIDTH:0] r_mem [DEPTH];

    // Write the addressed entry when the parent accepts a push
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Receive-side circular FIFO behind the UART receiver. Detects
//                the rising edge of rx_need_store, stores {parity, data}, and
//                presents the head through a valid/ready handshake. Tracks a
//                sticky overflow flag.
//                Optional macro UART_RX_FIFO_ERR_CNT_EN adds saturating
//                parity-error and framing-error counters; without it both
//                count outputs are tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = UART_WIDTH_MAX,
    parameter int CNT_W = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       rx_need_store,
    input  logic [WIDTH-1:0]           rx_bits,
    input  logic                       rx_error_parity,
    input  logic                       rx_error_stop_bit,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_error_parity,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       clear_errors,
    output logic [CNT_W-1:0]           error_count_parity,
    output logic [CNT_W-1:0]           error_count_stop
);

    localparam int           AW         = $clog2(DEPTH);
    localparam int           PAR_BIT    = entry_parity_bit(WIDTH);
    localparam logic [AW:0]  c_PTR_ONE  = 1;

    logic            r_ns_d;
    logic [AW:0]     r_wp;
    logic [AW:0]     r_rp;
    logic            r_overflow;
    logic            w_push_req;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push_acc;
    logic            w_drop;
    logic [WIDTH:0]  w_rd_word;

    assign w_push_req = rx_need_store & ~r_ns_d;
    assign w_empty    = (r_wp == r_rp);
    assign w_full     = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
    assign w_pop      = ~w_empty & out_ready;
    // A pop in the same cycle frees the slot the push writes into
    assign w_push_acc = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    // Delay rx_need_store for edge detect; reset high so a level present at reset release is ignored
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ns_d <= 1'b1;
        end else begin
            r_ns_d <= rx_need_store;
        end
    end

    // Advance write and read pointers; reset discards contents
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push_acc) begin
                r_wp <= r_wp + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rp <= r_rp + c_PTR_ONE;
            end
        end
    end

    // Sticky overflow; a drop coinciding with clear leaves it set
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (clear_errors) begin
            r_overflow <= w_drop;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clock),
        .i_we    (w_push_acc),
        .i_waddr (r_wp[AW-1:0]),
        .i_wdata ({rx_error_parity, rx_bits}),
        .i_raddr (r_rp[AW-1:0]),
        .o_rdata (w_rd_word)
    );

    assign out_valid        = ~w_empty;
    assign out_data         = w_rd_word[WIDTH-1:0];
    assign out_error_parity = w_rd_word[PAR_BIT];
    assign level            = r_wp - r_rp;
    assign overflow         = r_overflow;

`ifdef UART_RX_FIFO_ERR_CNT_EN
    localparam logic [CNT_W-1:0] c_CNT_ONE = 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic             r_se_d;
    logic [CNT_W-1:0] r_cnt_par;
    logic [CNT_W-1:0] r_cnt_stop;
    logic             w_stop_evt;
    logic             w_par_evt;

    assign w_stop_evt = rx_error_stop_bit & ~r_se_d;
    assign w_par_evt  = w_push_acc & rx_error_parity;

    // Delay the framing-error level for edge detect; reset high like r_ns_d
    always_ff @(posedge clock) begin
        if (reset) begin
            r_se_d <= 1'b1;
        end else begin
            r_se_d <= rx_error_stop_bit;
        end
    end

    // Saturating parity-error counter; an event in the clear cycle yields 1
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt_par <= '0;
        end else if (clear_errors) begin
            r_cnt_par <= w_par_evt ? c_CNT_ONE : '0;
        end else if (w_par_evt && (r_cnt_par != c_CNT_MAX)) begin
            r_cnt_par <= r_cnt_par + c_CNT_ONE;
        end
    end

    // Saturating framing-error counter; an event in the clear cycle yields 1
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt_stop <= '0;
        end else if (clear_errors) begin
            r_cnt_stop <= w_stop_evt ? c_CNT_ONE : '0;
        end else if (w_stop_evt && (r_cnt_stop != c_CNT_MAX)) begin
            r_cnt_stop <= r_cnt_stop + c_CNT_ONE;
        end
    end

    assign error_count_parity = r_cnt_par;
    assign error_count_stop   = r_cnt_stop;
`else
    // Framing-error level has no consumer when counting is disabled
    logic w_unused_stop;
    assign w_unused_stop      = rx_error_stop_bit;
    assign error_count_parity = '0;
    assign error_count_stop   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Directed self-checking bench for uart_rx_fifo (DEPTH 16,
//                WIDTH 16, CNT_W 8). Expected counter values follow
//                UART_RX_FIFO_ERR_CNT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx_need_store = 1'b0;
    logic [15:0] rx_bits = '0;
    logic        rx_error_parity = 1'b0;
    logic        rx_error_stop_bit = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_error_parity;
    logic [4:0]  level;
    logic        overflow;
    logic        clear_errors = 1'b0;
    logic [7:0]  error_count_parity;
    logic [7:0]  error_count_stop;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_fifo #(
        .DEPTH (16),
        .WIDTH (16),
        .CNT_W (8)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .rx_need_store      (rx_need_store),
        .rx_bits            (rx_bits),
        .rx_error_parity    (rx_error_parity),
        .rx_error_stop_bit  (rx_error_stop_bit),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_error_parity   (out_error_parity),
        .level              (level),
        .overflow           (overflow),
        .clear_errors       (clear_errors),
        .error_count_parity (error_count_parity),
        .error_count_stop   (error_count_stop)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One receiver frame: need_store high for one edge, then low for one edge
    task automatic push_frame(input logic [15:0] d, input logic p);
        rx_bits         = d;
        rx_error_parity = p;
        rx_need_store   = 1'b1;
        tick();
        rx_need_store   = 1'b0;
        rx_error_parity = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset, then one idle edge so the edge detector sees need_store low
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_valid",    32'(out_valid), 32'd0);
        check("rst_level",    32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_cnt_par",  32'(error_count_parity), 32'd0);
        check("rst_cnt_stop", 32'(error_count_stop), 32'd0);

        // Single frame: visible right after the sampling edge
        rx_bits       = 16'hA55A;
        rx_need_store = 1'b1;
        tick();
        rx_need_store = 1'b0;
        check("one_valid", 32'(out_valid), 32'd1);
        check("one_data",  32'(out_data), 32'h0000_A55A);
        check("one_level", 32'(level), 32'd1);
        tick();
        pop_one();
        check("one_pop_level", 32'(level), 32'd0);
        check("one_pop_valid", 32'(out_valid), 32'd0);

        // Fill to 16, then a 17th frame is dropped
        for (int i = 0; i < 16; i++) push_frame(16'(i), 1'b0);
        check("full_level",    32'(level), 32'd16);
        check("full_ovf0",     32'(overflow), 32'd0);
        push_frame(16'h00FF, 1'b0);
        check("drop_ovf",      32'(overflow), 32'd1);
        check("drop_level",    32'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("drain_data", 32'(out_data), 32'(i));
            pop_one();
        end
        check("drain_level",   32'(level), 32'd0);
        check("drain_valid",   32'(out_valid), 32'd0);
        check("ovf_sticky",    32'(overflow), 32'd1);

        // Clear, refill, then push while popping at full
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        check("clr_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) push_frame(16'h0100 + 16'(i), 1'b0);
        check("refill_level", 32'(level), 32'd16);
        rx_bits       = 16'h1234;
        rx_need_store = 1'b1;
        out_ready     = 1'b1;
        tick();
        rx_need_store = 1'b0;
        out_ready     = 1'b0;
        tick();
        check("pp_ovf",   32'(overflow), 32'd0);
        check("pp_level", 32'(level), 32'd16);
        check("pp_head",  32'(out_data), 32'h0000_0101);
        for (int i = 0; i < 15; i++) pop_one();
        check("pp_last",  32'(out_data), 32'h0000_1234);
        pop_one();
        check("pp_empty", 32'(out_valid), 32'd0);

        // Frame with a parity error
        push_frame(16'h0F0F, 1'b1);
        check("par_flag", 32'(out_error_parity), 32'd1);
        check("par_data", 32'(out_data), 32'h0000_0F0F);
        check("par_cnt",  32'(error_count_parity), CNT_EN ? 32'd1 : 32'd0);
        pop_one();

        // 300 framing-error edges saturate the 8-bit counter
        for (int i = 0; i < 300; i++) begin
            rx_error_stop_bit = 1'b1;
            tick();
            rx_error_stop_bit = 1'b0;
            tick();
        end
        check("stop_sat", 32'(error_count_stop), CNT_EN ? 32'd255 : 32'd0);

        // Clear coinciding with a framing-error edge leaves count at 1
        rx_error_stop_bit = 1'b1;
        clear_errors      = 1'b1;
        tick();
        clear_errors      = 1'b0;
        rx_error_stop_bit = 1'b0;
        check("clr_stop_evt", 32'(error_count_stop), CNT_EN ? 32'd1 : 32'd0);
        check("clr_par",      32'(error_count_parity), 32'd0);
        tick();

        // need_store held high across reset release must not push
        rx_need_store = 1'b1;
        rx_bits       = 16'hDEAD;
        reset         = 1'b1;
        tick();
        reset         = 1'b0;
        tick();
        tick();
        check("hold_valid", 32'(out_valid), 32'd0);
        check("hold_level", 32'(level), 32'd0);
        rx_need_store = 1'b0;
        tick();

        // Reset mid-operation with five entries
        for (int i = 0; i < 5; i++) push_frame(16'h5000 + 16'(i), 1'b0);
        check("five_level", 32'(level), 32'd5);
        reset = 1'b1;
        tick();
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
